// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: state encodings and datapath widths
// for the instruction-memory loader.
package imem_loader_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes into one big-endian 32-bit word.
// word_full flags the byte that completes the current word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            word <= '0;
            cnt  <= 2'd0;
        end else if (shift_en) begin
            word <= {word[WORD_W-BYTE_W-1:0], byte_in};
            cnt  <= cnt + 2'd1;
        end
    end

    assign word_full = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader writing packed words into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_ovf,
    output logic              chk_err
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = S_CHK;
`else
    localparam state_t END_ST = S_DONE;
`endif

    localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(2**ADDR_W);
    localparam logic [CNT_W:0] BASE  = (CNT_W+1)'(BASE_ADDR);

    state_t             state;
    state_t             nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   hdr_n;
    logic [CNT_W:0]     addr_w;
    logic [WORD_W-1:0]  word;
    logic               word_full;
    logic               fire;
    logic               shift_en;
    logic               pk_clr;
    logic               ovf;
    logic               last;
    logic               go;

    assign fire     = in_valid && in_ready;
    assign go       = (state == S_IDLE) && start;
    assign shift_en = fire && (state == S_DATA);
    assign pk_clr   = go;
    assign hdr_n    = {count[BYTE_W-1:0], in_data};
    // wide add so addresses past the top are seen, never wrapped
    assign addr_w   = BASE + {1'b0, idx};
    assign ovf      = addr_w >= DEPTH;
    assign last     = (idx + 16'd1) == count;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .shift_en  (shift_en),
        .byte_in   (in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (start) nxt = S_HDR_HI;
            S_HDR_HI: if (fire) nxt = S_HDR_LO;
            S_HDR_LO: if (fire) nxt = (hdr_n == '0) ? END_ST : S_DATA;
            S_DATA:   if (word_full) nxt = S_WRITE;
            S_WRITE:  nxt = last ? END_ST : S_DATA;
            S_CHK:    if (fire) nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        unique case (state)
            S_IDLE:   cpu_hold = 1'b0;
            S_HDR_HI,
            S_HDR_LO,
            S_DATA,
            S_CHK:    in_ready = 1'b1;
            S_WRITE:  imem_we  = !ovf;
            S_DONE:   done     = 1'b1;
            default:  cpu_hold = 1'b1;
        endcase
    end

    assign imem_addr  = (state == S_WRITE) ? addr_w[ADDR_W-1:0] : '0;
    assign imem_wdata = (state == S_WRITE) ? word : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            idx     <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (go) begin
                count   <= '0;
                idx     <= '0;
                err_ovf <= 1'b0;
            end
            if (fire && (state == S_HDR_HI || state == S_HDR_LO))
                count <= hdr_n;
            if (state == S_WRITE) begin
                idx <= idx + 16'd1;
                if (ovf) err_ovf <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xsum;

    always_ff @(posedge clk) begin
        if (!rst_n || go) begin
            xsum    <= '0;
            chk_err <= 1'b0;
        end else if (shift_en) begin
            xsum <= xsum ^ in_data;
        end else if (fire && state == S_CHK) begin
            chk_err <= (in_data != xsum);
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; frame-level model
// predicts writes, done timing and sticky error flags.
module tb_imem_loader;

    localparam int AW    = 4;
    localparam int BASE  = 12;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err_ovf;
    logic          chk_err;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err_ovf    (err_ovf),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int cyc;
        bit ovf;
        bit cerr;
    } dn_t;

    wr_t          wr_q[$];
    dn_t          dn_q[$];
    logic [31:0]  wq[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_bad = 0;
    int           dones = 0;
    logic [7:0]   xr;
    bit           f_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops predicted responses whenever the DUT presents one
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (imem_we) begin
                chk("we_in_ready", {63'd0, in_ready}, 64'd0);
                chk("we_cpu_hold", {63'd0, cpu_hold}, 64'd1);
                if (wr_q.size() == 0) begin
                    chk("we_pending", 64'(wr_q.size()), 64'd1);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("we_addr", 64'(imem_addr), 64'(w.addr));
                    chk("we_data", 64'(imem_wdata), 64'(w.data));
                    chk("we_cycle", 64'(cyc), 64'(w.cyc));
                end
            end
            if (done) begin
                chk("done_hold", {63'd0, cpu_hold}, 64'd1);
                chk("done_ready", {63'd0, in_ready}, 64'd0);
                chk("done_wr_left", 64'(wr_q.size()), 64'd0);
                if (dn_q.size() == 0) begin
                    chk("done_pending", 64'(dn_q.size()), 64'd1);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                    chk("err_ovf", {63'd0, err_ovf}, {63'd0, d.ovf});
                    chk("chk_err", {63'd0, chk_err}, {63'd0, d.cerr});
                end
                dones++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             output int acc);
        bit got;
        int tries;
        got = 1'b0;
        tries = 0;
        while (!got) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            got      = in_valid && in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            tries++;
            if (tries > 200) begin
                $display("FAIL byte_timeout: got no in_ready expected accept");
                $fatal(1);
            end
        end
        acc = cyc;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_after_start", {63'd0, cpu_hold}, 64'd1);
        xr    = 8'h00;
        f_ovf = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [31:0] w,
                             input bit gaps, output int acc);
        logic [7:0] b;
        for (int j = 0; j < 4; j++) begin
            b = w[31-8*j -: 8];
            send_byte(b, gaps, acc);
            xr = xr ^ b;
        end
        if (BASE + i < DEPTH) begin
            wr_t e;
            e.cyc  = acc;
            e.addr = AW'(BASE + i);
            e.data = w;
            wr_q.push_back(e);
        end else begin
            f_ovf = 1'b1;
        end
    endtask

    task automatic frame(input bit gaps, input bit bad_chk);
        int   n;
        int   acc;
        int   d0;
        int   t;
        bit   tail;
        dn_t  d;
        n = wq.size();
        start_frame();
        send_byte(8'(n >> 8), gaps, acc);
        send_byte(8'(n), gaps, acc);
        tail = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_word(i, wq[i], gaps, acc);
            tail = 1'b1;
        end
        d.cerr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_chk ? (xr ^ 8'h01) : xr, gaps, acc);
        tail   = 1'b0;
        d.cerr = bad_chk;
`endif
        d.cyc = acc + (tail ? 1 : 0);
        d.ovf = f_ovf;
        d0 = dones;
        dn_q.push_back(d);
        t = 0;
        while (dones == d0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (dones == d0) chk("done_timeout", 64'(dones), 64'(d0 + 1));
        @(negedge clk);
        chk("idle_hold", {63'd0, cpu_hold}, 64'd0);
        chk("idle_ready", {63'd0, in_ready}, 64'd0);
        chk("ovf_sticky", {63'd0, err_ovf}, {63'd0, f_ovf});
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_we", {63'd0, imem_we}, 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_hold", {63'd0, cpu_hold}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ovf", {63'd0, err_ovf}, 64'd0);
        chk("rst_chk", {63'd0, chk_err}, 64'd0);
    endtask

    initial begin
        int acc;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        wq = '{32'h12345678, 32'h9ABCDEF0};
        frame(1'b0, 1'b0);

        wq.delete();
        frame(1'b0, 1'b0);

        wq = '{$urandom, $urandom, $urandom};
        frame(1'b1, 1'b0);

        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back($urandom);
        frame(1'b1, 1'b0);

        wq = '{32'h01020408};
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);

        // abort mid-DATA after an overflowed word set err_ovf
        start_frame();
        send_byte(8'h00, 1'b0, acc);
        send_byte(8'h06, 1'b0, acc);
        for (int i = 0; i < 5; i++) send_word(i, $urandom, 1'b0, acc);
        send_byte(8'hA5, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        wr_q.delete();
        dn_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        wq = '{32'hCAFEF00D, 32'h0BADBEEF};
        frame(1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 6);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            frame(1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
